// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the uart_rx controller slice:
//   - rx_state_t  : controller FSM states (CORE_RST, ARMED, RECEIVING)
//   - DATA_W      : received byte width
//   - CPB_W       : width of the clks-per-bit value handed to the core
//   - FRAME_BITS  : bit periods allowed per frame before a timeout
//   - clamp_cpb() : forces a requested clks-per-bit value to at least 2
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int CPB_W      = 13;
  localparam int FRAME_BITS = 11;
  localparam int BIT_CNT_W  = 4;

  // Smallest clks-per-bit value the core can run with.
  localparam logic [CPB_W-1:0] CPB_MIN = 13'd2;

  typedef enum logic [1:0] {
    CORE_RST  = 2'd0,
    ARMED     = 2'd1,
    RECEIVING = 2'd2
  } rx_state_t;

  // A core programmed with 0 or 1 clks-per-bit cannot time a bit at all,
  // so such requests are raised to the minimum.
  function automatic logic [CPB_W-1:0] clamp_cpb(input logic [CPB_W-1:0] value);
    logic [CPB_W-1:0] result;
    if (value < CPB_MIN) begin
      result = CPB_MIN;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// rx_byte_fifo
// First-word-fall-through byte FIFO. The head entry is presented on rd_data
// whenever the FIFO is non-empty; a write becomes visible on the cycle after
// it is accepted.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data (dropped when full unless popping too)
//   push_data   : byte to write
//   pop         : remove head entry (ignored when empty)
//   rd_data     : head entry, 0 while empty
//   count       : occupancy, 0..DEPTH
//   full, empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module rx_byte_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == {(AW + 1){1'b0}});

  // Qualify requests: a pop frees a slot in the same cycle, so a push into
  // a full FIFO is still accepted when it coincides with a pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{(AW - 1){1'b0}}, 1'b1};
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // Head presentation; a stale slot is never shown while empty.
  always_comb begin
    if (empty) begin
      rd_data = {DATA_W{1'b0}};
    end else begin
      rd_data = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Sequences one uart_rx core: owns its active-low reset and clks-per-bit,
// arms it for each frame, watches for a frame that never completes, and
// buffers received bytes in a small FWFT FIFO for the host side.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cfg_cpb, cfg_wr     : request a new clks-per-bit (applied at next core reset)
//   rx_line             : raw serial line, same net the core samples
//   core_done/core_data : byte-complete pulse and byte from the core
//   core_rst_n/core_cpb : reset and clks-per-bit driven into the core
//   rd_en/rd_data/rd_valid/fifo_count : host-side FIFO interface
//   overrun, frame_err  : sticky error flags, cleared by clr_err
// Build option:
//   RX_STOP_CHECK_EN    : when defined, a done pulse with rx_line low (bad
//                         stop bit) drops the byte, flags frame_err and
//                         resets the core.
// ---------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int               FIFO_DEPTH  = 4,
  parameter int               RST_CYCLES  = 4,
  parameter logic [CPB_W-1:0] CPB_DEFAULT = 13'd433
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CPB_W-1:0]              cfg_cpb,
  input  logic                          cfg_wr,
  input  logic                          rx_line,
  input  logic                          core_done,
  input  logic [DATA_W-1:0]             core_data,
  output logic                          core_rst_n,
  output logic [CPB_W-1:0]              core_cpb,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int                   RC_W     = $clog2(RST_CYCLES) + 1;
  localparam logic [RC_W-1:0]      RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_next;
  logic [CPB_W-1:0]     timer;
  logic [CPB_W-1:0]     timer_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_next;
  logic [RC_W-1:0]      rst_cnt;
  logic [RC_W-1:0]      rst_cnt_next;
  logic [CPB_W-1:0]     pend_cpb;
  logic                 pend_valid;
  logic                 stop_ok;
  logic                 push;
  logic                 frame_evt;
  logic                 enter_rst;
  logic                 ovf_evt;
  logic                 fifo_full;
  logic                 fifo_empty;

`ifdef RX_STOP_CHECK_EN
  // The core raises done in the stop bit, so the line must be idle-high.
  assign stop_ok = rx_line;
`else
  assign stop_ok = 1'b1;
`endif

  // Next-state logic: core reset sequencing, arming, frame timeout.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    bit_next     = bit_cnt;
    rst_cnt_next = rst_cnt;
    push         = 1'b0;
    frame_evt    = 1'b0;
    case (state)
      CORE_RST: begin
        if (rst_cnt == RC_LAST) begin
          state_next   = ARMED;
          rst_cnt_next = {RC_W{1'b0}};
        end else begin
          rst_cnt_next = rst_cnt + {{(RC_W - 1){1'b0}}, 1'b1};
        end
      end
      ARMED: begin
        // A pending rate change is applied before the core sees another
        // start bit, so it wins over a falling line.
        if (pend_valid) begin
          state_next   = CORE_RST;
          rst_cnt_next = {RC_W{1'b0}};
        end else if (!rx_line) begin
          state_next = RECEIVING;
          timer_next = {CPB_W{1'b0}};
          bit_next   = {BIT_CNT_W{1'b0}};
        end else begin
          state_next = ARMED;
        end
      end
      RECEIVING: begin
        if (core_done) begin
          if (stop_ok) begin
            push       = 1'b1;
            state_next = ARMED;
          end else begin
            frame_evt    = 1'b1;
            state_next   = CORE_RST;
            rst_cnt_next = {RC_W{1'b0}};
          end
        end else if (timer == (core_cpb - {{(CPB_W - 1){1'b0}}, 1'b1})) begin
          // End of a bit period; after the last allowed one the core is
          // assumed stuck and is reset.
          if (bit_cnt == BIT_LAST) begin
            frame_evt    = 1'b1;
            state_next   = CORE_RST;
            rst_cnt_next = {RC_W{1'b0}};
          end else begin
            timer_next = {CPB_W{1'b0}};
            bit_next   = bit_cnt + {{(BIT_CNT_W - 1){1'b0}}, 1'b1};
          end
        end else begin
          timer_next = timer + {{(CPB_W - 1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next   = CORE_RST;
        rst_cnt_next = {RC_W{1'b0}};
      end
    endcase
    enter_rst = (state_next == CORE_RST) && (state != CORE_RST);
  end

  // A byte is lost only when the FIFO is full and nothing leaves this cycle.
  always_comb begin
    ovf_evt = push && fifo_full && !rd_en;
  end

  // State, counters, core-facing outputs, pending config and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CORE_RST;
      timer      <= {CPB_W{1'b0}};
      bit_cnt    <= {BIT_CNT_W{1'b0}};
      rst_cnt    <= {RC_W{1'b0}};
      core_rst_n <= 1'b0;
      core_cpb   <= CPB_DEFAULT;
      pend_cpb   <= {CPB_W{1'b0}};
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      bit_cnt    <= bit_next;
      rst_cnt    <= rst_cnt_next;
      core_rst_n <= (state_next != CORE_RST);
      // core_cpb only moves while the core is held in reset.
      if (enter_rst && pend_valid) begin
        core_cpb <= pend_cpb;
      end else begin
        core_cpb <= core_cpb;
      end
      // A write landing on the entry cycle stays pending for the next reset.
      if (cfg_wr) begin
        pend_cpb   <= clamp_cpb(cfg_cpb);
        pend_valid <= 1'b1;
      end else if (enter_rst) begin
        pend_valid <= 1'b0;
      end else begin
        pend_valid <= pend_valid;
      end
      // New events override a simultaneous clear.
      overrun   <= (overrun & ~clr_err) | ovf_evt;
      frame_err <= (frame_err & ~clr_err) | frame_evt;
    end
  end

  rx_byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (core_data),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed plus randomized bench for uart_rx_ctrl. A behavioural uart_rx
// drives rx_line bit by bit and pulses core_done mid stop bit; expected FIFO
// contents and flags come from a byte queue and two expected-flag bits.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [12:0]   cfg_cpb = 13'd0;
  logic          cfg_wr = 1'b0;
  logic          rx_line = 1'b1;
  logic          core_done = 1'b0;
  logic [7:0]    core_data = 8'd0;
  logic          core_rst_n;
  logic [12:0]   core_cpb;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] fifo_count;
  logic          overrun;
  logic          frame_err;
  logic          clr_err = 1'b0;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] q[$];
  bit         exp_ovr  = 1'b0;
  bit         exp_ferr = 1'b0;
  int         cur_cpb  = 433;

  uart_rx_ctrl #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .RST_CYCLES  (4),
    .CPB_DEFAULT (13'd433)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_cpb    (cfg_cpb),
    .cfg_wr     (cfg_wr),
    .rx_line    (rx_line),
    .core_done  (core_done),
    .core_data  (core_data),
    .core_rst_n (core_rst_n),
    .core_cpb   (core_cpb),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of the FIFO on an accepted byte.
  task automatic model_push(input logic [7:0] b);
    if (q.size() < FIFO_DEPTH) q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic wait_armed();
    for (int i = 0; i < 50 && core_rst_n !== 1'b1; i++) @(negedge clk);
    check("armed", 32'(core_rst_n), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(fifo_count), q.size());
    check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_ferr));
  endtask

  // One serial frame from the behavioural core at cur_cpb clocks per bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_val, input bit pop_at_done,
                            input bit clr_at_done, input int cfg_at, input logic [12:0] cfg_val);
    int done_at;
    wait_armed();
    done_at = 9 * cur_cpb + cur_cpb / 2;
    for (int c = 0; c <= done_at; c++) begin
      int bi;
      bi = c / cur_cpb;
      if (bi == 0) rx_line = 1'b0;
      else if (bi <= 8) rx_line = b[bi-1];
      else rx_line = stop_val;
      cfg_wr  = (c == cfg_at);
      cfg_cpb = cfg_val;
      if (c == done_at) begin
        core_done = 1'b1;
        core_data = b;
        check("cpb_in_frame", 32'(core_cpb), cur_cpb);
        if (clr_at_done) begin
          clr_err  = 1'b1;
          exp_ovr  = 1'b0;
          exp_ferr = 1'b0;
        end
        if (pop_at_done && q.size() > 0) begin
          check("rd_data_at_done", 32'(rd_data), 32'(q[0]));
          rd_en = 1'b1;
          q.delete(0);
        end
`ifdef RX_STOP_CHECK_EN
        if (!stop_val) exp_ferr = 1'b1;
        else model_push(b);
`else
        model_push(b);
`endif
      end
      @(negedge clk);
      core_done = 1'b0;
      rd_en     = 1'b0;
      clr_err   = 1'b0;
    end
    cfg_wr  = 1'b0;
    rx_line = 1'b1;
    repeat (cur_cpb / 2 + 2) @(negedge clk);
    check_status("frame");
  endtask

  task automatic pop_one();
    if (q.size() > 0) begin
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_data", 32'(rd_data), 32'(q[0]));
      q.delete(0);
    end else begin
      check("rd_valid_empty", 32'(rd_valid), 32'd0);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("count_after_pop", 32'(fifo_count), q.size());
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err  = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_frame_err", 32'(frame_err), 32'd0);
  endtask

  initial begin
    logic [7:0] dir_bytes[3];
    dir_bytes[0] = 8'h55;
    dir_bytes[1] = 8'hA3;
    dir_bytes[2] = 8'h00;

    // Reset release: core held in reset for four cycles.
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_core_cpb", 32'(core_cpb), 32'd433);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check_status("rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_low", 32'(core_rst_n), 32'd0);
    end
    @(negedge clk);
    check("rst_release_high", 32'(core_rst_n), 32'd1);

    // Three frames in order.
    for (int i = 0; i < 3; i++) send_frame(dir_bytes[i], 1'b1, 1'b0, 1'b0, -1, 13'd0);
    for (int i = 0; i < 3; i++) pop_one();
    check_status("three_frames");

    // Stuck-low line: timeout after 11 bit periods, then recovery.
    wait_armed();
    rx_line = 1'b0;
    repeat (11 * 433) @(negedge clk);
    check("timeout_not_yet", 32'(frame_err), 32'd0);
    @(negedge clk);
    exp_ferr = 1'b1;
    check("timeout_frame_err", 32'(frame_err), 32'd1);
    check("timeout_core_rst", 32'(core_rst_n), 32'd0);
    rx_line = 1'b1;
    clear_errors();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1, 13'd0);
    pop_one();

    // Rate change requested mid-frame waits for the frame to finish.
    send_frame(8'hC5, 1'b1, 1'b0, 1'b0, 2000, 13'd100);
    check("cpb_after_cfg", 32'(core_cpb), 32'd100);
    cur_cpb = 100;
    pop_one();
    send_frame(8'h6B, 1'b1, 1'b0, 1'b0, -1, 13'd0);
    pop_one();

    // Clamp of a too-small rate, then back to 100.
    cfg_cpb = 13'd1; cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    repeat (10) @(negedge clk);
    check("cpb_clamped", 32'(core_cpb), 32'd2);
    cfg_cpb = 13'd100; cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    repeat (10) @(negedge clk);
    check("cpb_restored", 32'(core_cpb), 32'd100);

    // Overflow: five bytes, no reads; fifth byte dropped.
    for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, 1'b0, -1, 13'd0);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overrun), 32'd1);
    // Another drop coinciding with a clear keeps the flag set.
    send_frame(8'h20, 1'b1, 1'b0, 1'b1, -1, 13'd0);
    check("ovf_clear_race", 32'(overrun), 32'd1);
    // Push and pop on a full FIFO: both happen, no new overrun.
    clear_errors();
    send_frame(8'h21, 1'b1, 1'b1, 1'b0, -1, 13'd0);
    for (int i = 0; i < 5; i++) pop_one();

    // Bad stop bit on 0x7E.
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, -1, 13'd0);
    while (q.size() > 0) pop_one();
    clear_errors();

    // Randomized traffic with random reads.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, 1'b1, ($urandom_range(0, 3) == 0), 1'b0, -1, 13'd0);
      if ($urandom_range(0, 1) == 1) pop_one();
    end
    while (q.size() > 0) pop_one();
    pop_one();
    clear_errors();

    // Reset in the middle of a frame with bytes buffered.
    send_frame(8'hA1, 1'b1, 1'b0, 1'b0, -1, 13'd0);
    send_frame(8'hA2, 1'b1, 1'b0, 1'b0, -1, 13'd0);
    wait_armed();
    rx_line = 1'b0;
    repeat (150) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    rx_line = 1'b1;
    q.delete();
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    cur_cpb  = 433;
    check("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("midrst_core_cpb", 32'(core_cpb), 32'd433);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check_status("midrst");
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, -1, 13'd0);
    pop_one();
    check_status("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
